// File: rtl/hand_token_ctrl.sv
// hand_token_ctrl: owns the turn token for NUM_PLAYERS players and decodes it into a
// one-hot handed vector plus the holder index.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   start         begin a round (only looked at while idle)
//   start_player  first holder; out-of-range values start at player 0
//   stop          end the round and return to idle
//   pass_req      per-player pass request, level-sampled every cycle
//   dir           rotation direction: 0 = holder+1, 1 = holder-1 (both wrap)
//   holder        current token holder index
//   handed        one-hot of holder while a round is active, zero otherwise
//   round_active  high while a round is active
//   timeout_pulse one-cycle pulse following a forced pass
//   pass_count    voluntary plus forced passes this round, saturating at 255
//
// All outputs come straight from registers.

module hand_token_ctrl #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TIMEOUT     = 15,
  localparam int unsigned PW         = $clog2(NUM_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PW-1:0]          start_player,
  input  logic                   stop,
  input  logic [NUM_PLAYERS-1:0] pass_req,
  input  logic                   dir,
  output logic [PW-1:0]          holder,
  output logic [NUM_PLAYERS-1:0] handed,
  output logic                   round_active,
  output logic                   timeout_pulse,
  output logic [7:0]             pass_count
);

  // A zero-width timer is not legal, so TIMEOUT=0 keeps a 1-bit timer parked at 0.
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] LastIdx   = PW'(NUM_PLAYERS - 1);
  localparam logic [TW-1:0] TimerLast = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {StIdle, StActive} state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            holder_q, holder_d;
  logic [NUM_PLAYERS-1:0]   handed_q, handed_d;
  logic                     active_q, active_d;
  logic                     pulse_q, pulse_d;
  logic [7:0]               count_q, count_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [PW-1:0]            next_holder;
  logic                     advance;

  // Neighbour of the current holder in the requested direction.
  always_comb begin
    if (dir) begin
      next_holder = (holder_q == '0) ? LastIdx : holder_q - 1'b1;
    end else begin
      next_holder = (holder_q == LastIdx) ? '0 : holder_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    holder_d = holder_q;
    timer_d  = timer_q;
    count_d  = count_q;
    pulse_d  = 1'b0;
    advance  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StActive;
          holder_d = (32'(start_player) >= NUM_PLAYERS) ? '0 : start_player;
          timer_d  = '0;
          count_d  = '0;
        end
      end
      StActive: begin
        // Priority: stop, then the holder's own request, then the turn timer.
        if (stop) begin
          state_d = StIdle;
        end else if (pass_req[holder_q]) begin
          advance = 1'b1;
        end else if ((TIMEOUT != 0) && (timer_q == TimerLast)) begin
          advance = 1'b1;
          pulse_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (advance) begin
      holder_d = next_holder;
      timer_d  = '0;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end

    active_d = (state_d == StActive);
    handed_d = active_d ? (NUM_PLAYERS'(1) << holder_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      holder_q <= '0;
      handed_q <= '0;
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      holder_q <= holder_d;
      handed_q <= handed_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
    end
  end

  assign holder        = holder_q;
  assign handed        = handed_q;
  assign round_active  = active_q;
  assign timeout_pulse = pulse_q;
  assign pass_count    = count_q;

endmodule

// File: tb/tb_hand_token_ctrl.sv
// Bench for hand_token_ctrl: a 4-player/TIMEOUT=15 instance and a 3-player/no-timeout
// instance. Stimulus queues expected snapshots tagged with the cycle they apply to; a
// negedge monitor pops and compares them against the live outputs.

module tb_hand_token_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-player instance
  logic       start4 = 1'b0, stop4 = 1'b0, dir4 = 1'b0;
  logic [1:0] sp4 = '0;
  logic [3:0] pr4 = '0;
  logic [1:0] holder4;
  logic [3:0] handed4;
  logic       active4, pulse4;
  logic [7:0] count4;

  // 3-player instance
  logic       start3 = 1'b0, stop3 = 1'b0, dir3 = 1'b0;
  logic [1:0] sp3 = '0;
  logic [2:0] pr3 = '0;
  logic [1:0] holder3;
  logic [2:0] handed3;
  logic       active3, pulse3;
  logic [7:0] count3;

  hand_token_ctrl #(.NUM_PLAYERS(4), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .start_player(sp4), .stop(stop4),
    .pass_req(pr4), .dir(dir4), .holder(holder4), .handed(handed4),
    .round_active(active4), .timeout_pulse(pulse4), .pass_count(count4)
  );

  hand_token_ctrl #(.NUM_PLAYERS(3), .TIMEOUT(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .start_player(sp3), .stop(stop3),
    .pass_req(pr3), .dir(dir3), .holder(holder3), .handed(handed3),
    .round_active(active3), .timeout_pulse(pulse3), .pass_count(count3)
  );

  typedef struct {
    string      name;
    int         cyc;
    bit         which;  // 0 = dut4, 1 = dut3
    logic [1:0] h;
    logic [3:0] hd;
    logic       act;
    logic       pul;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t       e;
      logic [1:0] ah;
      logic [3:0] ahd;
      logic       aact, apul;
      logic [7:0] acnt;
      e = q.pop_front();
      if (e.which) begin
        ah = holder3; ahd = {1'b0, handed3}; aact = active3; apul = pulse3; acnt = count3;
      end else begin
        ah = holder4; ahd = handed4; aact = active4; apul = pulse4; acnt = count4;
      end
      checks++;
      if (e.cyc != cyc || ah !== e.h || ahd !== e.hd || aact !== e.act ||
          apul !== e.pul || acnt !== e.cnt) begin
        errors++;
        $display("FAIL %s (cyc %0d/%0d): got holder=%0d handed=%b active=%b pulse=%b count=%0d, want holder=%0d handed=%b active=%b pulse=%b count=%0d",
                 e.name, cyc, e.cyc, ah, ahd, aact, apul, acnt,
                 e.h, e.hd, e.act, e.pul, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Queue a snapshot expected at this cycle's negedge.
  task automatic chk(input bit which, input string name, input logic [1:0] h,
                     input logic [3:0] hd, input logic act, input logic pul,
                     input logic [7:0] cnt);
    exp_t e;
    e.name = name; e.cyc = cyc; e.which = which;
    e.h = h; e.hd = hd; e.act = act; e.pul = pul; e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    steps(2);
    rst = 1'b0;
    chk(0, "reset4", 2'd0, 4'b0000, 0, 0, 8'd0);
    chk(1, "reset3", 2'd0, 4'b0000, 0, 0, 8'd0);

    // Start at player 2, rotate up.
    sp4 = 2'd2; dir4 = 1'b0; start4 = 1'b1;
    step(); start4 = 1'b0;
    chk(0, "start_p2", 2'd2, 4'b0100, 1, 0, 8'd0);

    pr4 = 4'b0100;
    step(); pr4 = 4'b0000;
    chk(0, "pass_up", 2'd3, 4'b1000, 1, 0, 8'd1);

    // Non-holder request and a start while active: nothing changes.
    pr4 = 4'b0001; start4 = 1'b1; sp4 = 2'd0;
    step(); pr4 = 4'b0000; start4 = 1'b0;
    chk(0, "nonholder_ignored", 2'd3, 4'b1000, 1, 0, 8'd1);

    dir4 = 1'b1; pr4 = 4'b1000;
    step();
    chk(0, "pass_down", 2'd2, 4'b0100, 1, 0, 8'd2);

    pr4 = 4'b1011;
    step();
    chk(0, "multi_req_no_holder", 2'd2, 4'b0100, 1, 0, 8'd2);

    pr4 = 4'b1111;
    step();
    chk(0, "multi_req_holder", 2'd1, 4'b0010, 1, 0, 8'd3);

    // Stop beats a simultaneous holder request.
    pr4 = 4'b0010; stop4 = 1'b1;
    step(); pr4 = 4'b0000; stop4 = 1'b0;
    chk(0, "stop_wins", 2'd1, 4'b0000, 0, 0, 8'd3);

    sp4 = 2'd0; start4 = 1'b1;
    step(); start4 = 1'b0;
    chk(0, "restart_p0", 2'd0, 4'b0001, 1, 0, 8'd0);

    pr4 = 4'b0001;
    step(); pr4 = 4'b0000;
    chk(0, "wrap_down", 2'd3, 4'b1000, 1, 0, 8'd1);

    // Forced pass fires on the 15th idle edge after the last pass.
    steps(14);
    chk(0, "pre_timeout", 2'd3, 4'b1000, 1, 0, 8'd1);
    step();
    chk(0, "timeout_fire", 2'd2, 4'b0100, 1, 1, 8'd2);
    step();
    chk(0, "timeout_pulse_end", 2'd2, 4'b0100, 1, 0, 8'd2);

    // Voluntary pass on the very edge the timeout would fire: no pulse.
    steps(13);
    pr4 = 4'b0100;
    step(); pr4 = 4'b0000;
    chk(0, "pass_at_timeout", 2'd1, 4'b0010, 1, 0, 8'd3);
    step();
    chk(0, "no_late_pulse", 2'd1, 4'b0010, 1, 0, 8'd3);

    // Async reset mid-round, observed before the next clock edge.
    step();
    rst = 1'b1;
    chk(0, "async_rst", 2'd0, 4'b0000, 0, 0, 8'd0);
    step();
    rst = 1'b0;

    // Timer restarts from entry after reset.
    sp4 = 2'd1; dir4 = 1'b0; start4 = 1'b1;
    step(); start4 = 1'b0;
    chk(0, "start_after_rst", 2'd1, 4'b0010, 1, 0, 8'd0);
    steps(14);
    chk(0, "entry_pre_timeout", 2'd1, 4'b0010, 1, 0, 8'd0);
    step();
    chk(0, "entry_timeout", 2'd2, 4'b0100, 1, 1, 8'd1);
    stop4 = 1'b1;
    step(); stop4 = 1'b0;
    chk(0, "stop_hold", 2'd2, 4'b0000, 0, 0, 8'd1);

    // 3 players: out-of-range start, no timeout, saturation.
    sp3 = 2'd3; start3 = 1'b1;
    step(); start3 = 1'b0;
    chk(1, "n3_clamp", 2'd0, 4'b0001, 1, 0, 8'd0);
    steps(20);
    chk(1, "n3_no_timeout", 2'd0, 4'b0001, 1, 0, 8'd0);
    pr3 = 3'b111;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1)   chk(1, "n3_pass1",   2'd1, 4'b0010, 1, 0, 8'd1);
      if (i == 2)   chk(1, "n3_pass2",   2'd2, 4'b0100, 1, 0, 8'd2);
      if (i == 3)   chk(1, "n3_wrap",    2'd0, 4'b0001, 1, 0, 8'd3);
      if (i == 255) chk(1, "n3_sat255",  2'd0, 4'b0001, 1, 0, 8'd255);
      if (i == 256) chk(1, "n3_sat_hold", 2'd1, 4'b0010, 1, 0, 8'd255);
      if (i == 300) chk(1, "n3_sat_300", 2'd0, 4'b0001, 1, 0, 8'd255);
    end
    pr3 = 3'b000;
    step();
    chk(1, "n3_release", 2'd0, 4'b0001, 1, 0, 8'd255);

    steps(2);
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
